// File: rtl/uart_pkg.sv
// Shared UART FIFO types and defaults.
// fifo_status_t packs the FIFO flags so they can be mapped straight onto a status CSR.
package uart_pkg;

   localparam int unsigned UART_DATA_W  = 8;
   localparam int unsigned UART_FIFO_AW = 9;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram_sdp.sv
// Simple-dual-port RAM with a registered read port.
// The storage array has no reset, so it can map onto iCE40 SB_RAM40_4K block RAM.
module uart_fifo_ram_sdp #(
   parameter int unsigned AW = 9,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wd,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= wd;
      if (ren) rd_q <= mem_q[raddr];
   end

   assign rd = rd_q;

endmodule

// File: rtl/uart_bram_fifo.sv
// Synchronous BRAM-backed byte FIFO for the UART: occupancy count, thresholds, flush, and sticky
// overflow/underflow flags. The read port is registered, so popped data appears one cycle later.
module uart_bram_fifo
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = UART_FIFO_AW,
   parameter int unsigned DATA_WIDTH   = UART_DATA_W,
   parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
   parameter int unsigned AEMPTY_LEVEL = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DepthCnt  = CW'(DEPTH);
   localparam logic [CW-1:0] AfullCnt  = CW'(AFULL_LEVEL);
   localparam logic [CW-1:0] AemptyCnt = CW'(AEMPTY_LEVEL);
   localparam logic [CW-1:0] CntOne    = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);

   if (!(AEMPTY_LEVEL > 0 && AEMPTY_LEVEL < AFULL_LEVEL && AFULL_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("uart_bram_fifo: need 0 < AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_seen_q, rd_seen_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  push_ok, pop_ok;
   logic [DATA_WIDTH-1:0] ram_rd;
   fifo_status_t          status;

   always_comb begin
      status.full         = (count_q == DepthCnt);
      status.empty        = (count_q == '0);
      status.almost_full  = (count_q >= AfullCnt);
      status.almost_empty = (count_q <= AemptyCnt);
      status.overflow     = overflow_q;
      status.underflow    = underflow_q;
   end

   // Flush wins over everything: no RAM access and no flag update in that cycle.
   assign push_ok = wr_en && !status.full && !flush;
   assign pop_ok  = rd_en && !status.empty && !flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_valid_d  = pop_ok;
      rd_seen_d   = rd_seen_q | pop_ok;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_ok) rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (!flush && wr_en && status.full) overflow_d = 1'b1;
      if (!flush && rd_en && status.empty) underflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_seen_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         rd_seen_q   <= rd_seen_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   uart_fifo_ram_sdp #(
      .AW (ADDR_WIDTH),
      .DW (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .wen   (push_ok),
      .waddr (wr_ptr_q),
      .wd    (wd),
      .ren   (pop_ok),
      .raddr (rd_ptr_q),
      .rd    (ram_rd)
   );

   // The BRAM read register cannot be reset, so rd reads as zero until the first pop after reset.
   assign rd           = rd_seen_q ? ram_rd : '0;
   assign rd_valid     = rd_valid_q;
   assign count        = count_q;
   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = status.overflow;
   assign underflow    = status.underflow;

endmodule

// File: tb/tb_uart_bram_fifo.sv
// Directed bench for uart_bram_fifo at depth 4 (AFULL_LEVEL=3, AEMPTY_LEVEL=1).
module tb_uart_bram_fifo;

   logic       clk = 1'b0;
   logic       rst, flush, wr_en, rd_en, err_clr;
   logic [7:0] wd, rd;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_bram_fifo #(
      .ADDR_WIDTH   (2),
      .DATA_WIDTH   (8),
      .AFULL_LEVEL  (3),
      .AEMPTY_LEVEL (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wr_en        (wr_en),
      .wd           (wd),
      .rd_en        (rd_en),
      .rd           (rd),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic r);
      wr_en = w;
      wd    = d;
      rd_en = r;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; err_clr = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_empty", 16'(empty), 16'd1);
      chk("rst_full", 16'(full), 16'd0);
      chk("rst_count", 16'(count), 16'd0);
      chk("rst_aempty", 16'(almost_empty), 16'd1);
      chk("rst_afull", 16'(almost_full), 16'd0);
      chk("rst_ovf", 16'(overflow), 16'd0);
      chk("rst_unf", 16'(underflow), 16'd0);
      chk("rst_rd", 16'(rd), 16'h00);
      chk("rst_rdv", 16'(rd_valid), 16'd0);

      // Push three, pop three.
      drive(1'b1, 8'h11, 1'b0); tick();
      chk("p1_count", 16'(count), 16'd1);
      chk("p1_aempty", 16'(almost_empty), 16'd1);
      drive(1'b1, 8'h22, 1'b0); tick();
      chk("p2_aempty", 16'(almost_empty), 16'd0);
      drive(1'b1, 8'h33, 1'b0); tick();
      chk("p3_count", 16'(count), 16'd3);
      chk("p3_afull", 16'(almost_full), 16'd1);
      drive(1'b0, 8'h00, 1'b1); tick();
      chk("q1_rdv", 16'(rd_valid), 16'd1);
      chk("q1_rd", 16'(rd), 16'h11);
      chk("q1_count", 16'(count), 16'd2);
      tick();
      chk("q2_rd", 16'(rd), 16'h22);
      tick();
      chk("q3_rd", 16'(rd), 16'h33);
      chk("q3_count", 16'(count), 16'd0);
      chk("q3_empty", 16'(empty), 16'd1);
      drive(1'b0, 8'h00, 1'b0); tick();
      chk("idle_rdv", 16'(rd_valid), 16'd0);
      chk("idle_rd_hold", 16'(rd), 16'h33);

      // Fill to full, then one rejected push.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'hA0 + 8'(i), 1'b0); tick();
      end
      chk("fill_count", 16'(count), 16'd4);
      chk("fill_full", 16'(full), 16'd1);
      chk("fill_afull", 16'(almost_full), 16'd1);
      chk("fill_ovf0", 16'(overflow), 16'd0);
      drive(1'b1, 8'hA4, 1'b0); tick();
      chk("ovf_set", 16'(overflow), 16'd1);
      chk("ovf_count", 16'(count), 16'd4);
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_rd", 16'(rd), 16'hA0 + 16'(i));
         chk("drain_rdv", 16'(rd_valid), 16'd1);
      end
      chk("drain_empty", 16'(empty), 16'd1);
      tick();
      chk("unf_set", 16'(underflow), 16'd1);
      chk("unf_rdv", 16'(rd_valid), 16'd0);
      chk("unf_rd_hold", 16'(rd), 16'hA3);
      drive(1'b0, 8'h00, 1'b0); err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr_ovf", 16'(overflow), 16'd0);
      chk("clr_unf", 16'(underflow), 16'd0);

      // Interleaved stream of 0..9 through the wrapping pointers.
      drive(1'b1, 8'd0, 1'b0); tick();
      for (int i = 1; i < 10; i++) begin
         drive(1'b1, 8'(i), 1'b1); tick();
         chk("wrap_rd", 16'(rd), 16'(i - 1));
         chk("wrap_count", 16'(count), 16'd1);
      end
      drive(1'b0, 8'h00, 1'b1); tick();
      chk("wrap_last", 16'(rd), 16'd9);
      chk("wrap_empty", 16'(empty), 16'd1);

      // Push+pop while empty: push wins, pop is rejected.
      drive(1'b1, 8'h77, 1'b1); tick();
      chk("pe_count", 16'(count), 16'd1);
      chk("pe_unf", 16'(underflow), 16'd1);
      chk("pe_rdv", 16'(rd_valid), 16'd0);
      chk("pe_ovf", 16'(overflow), 16'd0);
      drive(1'b1, 8'h78, 1'b0); tick();
      drive(1'b1, 8'h79, 1'b0); tick();
      drive(1'b1, 8'h7A, 1'b0); tick();
      chk("pf_full", 16'(full), 16'd1);
      // Push+pop while full: pop wins, push is rejected.
      drive(1'b1, 8'h7B, 1'b1); tick();
      chk("pf_count", 16'(count), 16'd3);
      chk("pf_ovf", 16'(overflow), 16'd1);
      chk("pf_rd", 16'(rd), 16'h77);
      chk("pf_rdv", 16'(rd_valid), 16'd1);
      drive(1'b0, 8'h00, 1'b0); err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr2_ovf", 16'(overflow), 16'd0);
      chk("clr2_unf", 16'(underflow), 16'd0);
      drive(1'b1, 8'h7C, 1'b0); tick();
      err_clr = 1'b1; drive(1'b1, 8'h7D, 1'b0); tick(); err_clr = 1'b0;
      chk("setwins_ovf", 16'(overflow), 16'd1);
      drive(1'b0, 8'h00, 1'b0); err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clr3_ovf", 16'(overflow), 16'd0);

      // Flush with three entries and both requests active.
      drive(1'b0, 8'h00, 1'b1); tick();
      chk("pre_flush_rd", 16'(rd), 16'h78);
      chk("pre_flush_count", 16'(count), 16'd3);
      flush = 1'b1; drive(1'b1, 8'hEE, 1'b1); tick(); flush = 1'b0;
      chk("fl_count", 16'(count), 16'd0);
      chk("fl_empty", 16'(empty), 16'd1);
      chk("fl_rdv", 16'(rd_valid), 16'd0);
      chk("fl_ovf", 16'(overflow), 16'd0);
      chk("fl_unf", 16'(underflow), 16'd0);
      chk("fl_rd_hold", 16'(rd), 16'h78);
      drive(1'b1, 8'h5A, 1'b0); tick();
      chk("post_fl_count", 16'(count), 16'd1);
      drive(1'b0, 8'h00, 1'b1); tick();
      chk("post_fl_rd", 16'(rd), 16'h5A);
      chk("post_fl_rdv", 16'(rd_valid), 16'd1);

      // Asynchronous reset mid-operation.
      drive(1'b1, 8'h42, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b1); tick();
      chk("mid_rdv_pre", 16'(rd_valid), 16'd1);
      drive(1'b0, 8'h00, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_rdv", 16'(rd_valid), 16'd0);
      chk("mid_rst_count", 16'(count), 16'd0);
      chk("mid_rst_rd", 16'(rd), 16'h00);
      chk("mid_rst_empty", 16'(empty), 16'd1);
      tick();
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
